// File: rtl/video_ram_arbiter.sv
// Single-port video RAM arbiter: scan-out fetches get absolute priority,
// CPU writes fill the free slots. All state advances on the falling edge of vga_clk.
module video_ram_arbiter #(
    parameter int unsigned             ADDR_W      = 15,
    parameter logic [ADDR_W-1:0]       FB_BASE     = 15'h0800,
    parameter int unsigned             LINE_STRIDE = 256,
    parameter int unsigned             H_PIXELS    = 160,
    parameter int unsigned             V_ROWS      = 120,
    parameter int unsigned             REP         = 4
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              blank_n,
    input  logic              VS,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        pixel,
    output logic              pixel_valid
);

    localparam int unsigned PH_W  = (REP > 1)      ? $clog2(REP)      : 1;
    localparam int unsigned X_W   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned ROW_W = (V_ROWS > 1)   ? $clog2(V_ROWS)   : 1;

    localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(REP - 1);
    localparam logic [X_W-1:0]   X_MAX   = X_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        VID_RD,
        CPU_WR
    } state_t;

    state_t             state, state_n;
    logic [PH_W-1:0]    phase;
    logic [X_W-1:0]     x;
    logic [PH_W-1:0]    rep;
    logic [ROW_W-1:0]   row;
    logic               blank_q, blank_q2;
    logic [ADDR_W-1:0]  vid_addr;
    logic [ADDR_W-1:0]  addr_n;
    logic [7:0]         wdata_n;

    assign vid_addr = FB_BASE + ADDR_W'(row) * ADDR_W'(LINE_STRIDE) + ADDR_W'(x);

    // Scan position: phase/x within a row, rep/row across scan lines.
    always_ff @(negedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            x        <= '0;
            rep      <= '0;
            row      <= '0;
            blank_q  <= 1'b0;
            blank_q2 <= 1'b0;
        end else begin
            blank_q  <= blank_n;
            blank_q2 <= blank_q;

            if (blank_n) begin
                if (phase == PH_MAX) begin
                    phase <= '0;
                    if (x != X_MAX) x <= x + 1'b1;
                end else begin
                    phase <= phase + 1'b1;
                end
            end else begin
                phase <= '0;
                x     <= '0;
            end

            if (!VS) begin
                rep <= '0;
                row <= '0;
            end else if (blank_q && !blank_n) begin
                if (rep == PH_MAX) begin
                    rep <= '0;
                    if (row != ROW_MAX) row <= row + 1'b1;
                end else begin
                    rep <= rep + 1'b1;
                end
            end
        end
    end

    // Slot decision for the RAM cycle launched at this edge.
    always_comb begin
        state_n = IDLE;
        addr_n  = ram_addr;
        wdata_n = ram_wdata;
        if (blank_n && phase == '0) begin
            state_n = VID_RD;
            addr_n  = vid_addr;
        end else if (cpu_req && !cpu_ack) begin
            state_n = CPU_WR;
            addr_n  = cpu_addr;
            wdata_n = cpu_wdata;
        end
    end

    always_ff @(negedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            cpu_ack     <= 1'b0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            ram_re    <= (state_n == VID_RD);
            ram_we    <= (state_n == CPU_WR);
            cpu_ack   <= (state_n == CPU_WR);

            // Clear two edges after blank falls so pixel tracks the 2-clock-delayed blank.
            if (!blank_q && blank_q2) begin
                pixel       <= '0;
                pixel_valid <= 1'b0;
            end else if (state == VID_RD) begin
                pixel       <= ram_rdata;
                pixel_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Bench for video_ram_arbiter: fixed vector table, model-checked random scan
// traffic, and directed line/saturation/reset-abort sequences.
module tb_video_ram_arbiter;

    localparam int AW = 15;

    logic          vga_clk;
    logic          reset_n;
    logic          blank_n;
    logic          VS;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic          ram_re;
    logic [7:0]    ram_rdata;
    logic [7:0]    pixel;
    logic          pixel_valid;

    video_ram_arbiter #(
        .ADDR_W(15), .FB_BASE(15'h0800), .LINE_STRIDE(256),
        .H_PIXELS(160), .V_ROWS(120), .REP(4)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .blank_n(blank_n), .VS(VS),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .pixel(pixel), .pixel_valid(pixel_valid)
    );

    initial vga_clk = 1'b1;
    always #5 vga_clk = ~vga_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: scan position as plain line/clock counts.
    int            m_lines, m_vis;
    logic          m_re, m_we, m_ack, m_pv, m_bh1, m_bh2;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wd, m_pix;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_lines = 0; m_vis = 0;
        m_re = 0; m_we = 0; m_ack = 0; m_pv = 0; m_bh1 = 0; m_bh2 = 0;
        m_addr = '0; m_wd = '0; m_pix = '0;
    endtask

    task automatic model_step();
        int a;
        if (!m_bh1 && m_bh2) begin
            m_pv = 0; m_pix = '0;
        end else if (m_re) begin
            m_pv = 1; m_pix = ram_rdata;
        end
        if (blank_n && (m_vis % 4 == 0)) begin
            a = 'h0800 + imin(m_lines / 4, 119) * 256 + imin(m_vis / 4, 159);
            m_addr = AW'(a % (1 << AW));
            m_re = 1; m_we = 0; m_ack = 0;
        end else if (cpu_req && !m_ack) begin
            m_addr = cpu_addr; m_wd = cpu_wdata;
            m_re = 0; m_we = 1; m_ack = 1;
        end else begin
            m_re = 0; m_we = 0; m_ack = 0;
        end
        if (blank_n) m_vis++; else m_vis = 0;
        if (!VS) m_lines = 0;
        else if (!blank_n && m_bh1) m_lines++;
        m_bh2 = m_bh1;
        m_bh1 = blank_n;
    endtask

    task automatic cyc(input logic b, input logic v);
        blank_n   = b;
        VS        = v;
        cpu_req   = ($urandom_range(0, 1) == 1);
        cpu_addr  = AW'($urandom);
        cpu_wdata = 8'($urandom);
        ram_rdata = 8'($urandom);
        @(negedge vga_clk);
        #2;
        model_step();
        chk("ram_re",      32'(ram_re),      32'(m_re));
        chk("ram_we",      32'(ram_we),      32'(m_we));
        chk("cpu_ack",     32'(cpu_ack),     32'(m_ack));
        chk("ram_addr",    32'(ram_addr),    32'(m_addr));
        chk("ram_wdata",   32'(ram_wdata),   32'(m_wd));
        chk("pixel",       32'(pixel),       32'(m_pix));
        chk("pixel_valid", 32'(pixel_valid), 32'(m_pv));
        chk("we_re_excl",  32'(ram_we & ram_re), 32'd0);
    endtask

    task automatic run_line(input int vis, input int blk, output int nrd,
                            output logic [AW-1:0] first_a, output logic [AW-1:0] last_a);
        nrd = 0; first_a = '0; last_a = '0;
        for (int i = 0; i < vis; i++) begin
            cyc(1'b1, 1'b1);
            if (ram_re) begin
                if (nrd == 0) first_a = ram_addr;
                last_a = ram_addr;
                nrd++;
            end
        end
        for (int i = 0; i < blk; i++) cyc(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_ram_we",  32'(ram_we),  32'd0);
        chk("rst_ram_re",  32'(ram_re),  32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_addr",    32'(ram_addr), 32'd0);
        chk("rst_wdata",   32'(ram_wdata), 32'd0);
        chk("rst_pixel",   32'(pixel),   32'd0);
        chk("rst_pv",      32'(pixel_valid), 32'd0);
        repeat (2) @(negedge vga_clk);
        @(posedge vga_clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic          blank, vs, req;
        logic [AW-1:0] caddr;
        logic          re, we, ack;
        logic [AW-1:0] addr;
        logic          pv;
        logic [7:0]    pix;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic b, input logic v, input logic r, input logic [AW-1:0] ca,
                                input logic re, input logic we, input logic ack,
                                input logic [AW-1:0] a, input logic pv, input logic [7:0] px);
        vec_t t;
        t.blank = b; t.vs = v; t.req = r; t.caddr = ca;
        t.re = re; t.we = we; t.ack = ack; t.addr = a; t.pv = pv; t.pix = px;
        return t;
    endfunction

    int            nrd;
    logic [AW-1:0] fa, la;

    initial begin
        reset_n = 1'b0; blank_n = 1'b0; VS = 1'b1; cpu_req = 1'b0;
        cpu_addr = '0; cpu_wdata = 8'h3C; ram_rdata = 8'hA5;

        // blank/vs/req/cpu_addr -> re/we/ack/addr/pixel_valid/pixel
        tbl[0]  = mk(0, 0, 0, 15'h1234, 0, 0, 0, 15'h0000, 0, 8'h00);
        tbl[1]  = mk(0, 1, 1, 15'h1234, 0, 1, 1, 15'h1234, 0, 8'h00);
        tbl[2]  = mk(0, 1, 1, 15'h1234, 0, 0, 0, 15'h1234, 0, 8'h00);
        tbl[3]  = mk(0, 1, 1, 15'h1234, 0, 1, 1, 15'h1234, 0, 8'h00);
        tbl[4]  = mk(0, 1, 1, 15'h1234, 0, 0, 0, 15'h1234, 0, 8'h00);
        tbl[5]  = mk(0, 1, 1, 15'h1234, 0, 1, 1, 15'h1234, 0, 8'h00);
        tbl[6]  = mk(0, 1, 1, 15'h1234, 0, 0, 0, 15'h1234, 0, 8'h00);
        tbl[7]  = mk(1, 1, 1, 15'h2222, 1, 0, 0, 15'h0800, 0, 8'h00);
        tbl[8]  = mk(1, 1, 1, 15'h2222, 0, 1, 1, 15'h2222, 1, 8'hA5);
        tbl[9]  = mk(1, 1, 1, 15'h2222, 0, 0, 0, 15'h2222, 1, 8'hA5);
        tbl[10] = mk(1, 1, 1, 15'h2222, 0, 1, 1, 15'h2222, 1, 8'hA5);
        tbl[11] = mk(1, 1, 1, 15'h2222, 1, 0, 0, 15'h0801, 1, 8'hA5);
        tbl[12] = mk(0, 1, 0, 15'h2222, 0, 0, 0, 15'h0801, 1, 8'hA5);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            blank_n = tbl[i].blank; VS = tbl[i].vs; cpu_req = tbl[i].req; cpu_addr = tbl[i].caddr;
            @(negedge vga_clk);
            #2;
            chk($sformatf("tbl%0d_re", i),   32'(ram_re),      32'(tbl[i].re));
            chk($sformatf("tbl%0d_we", i),   32'(ram_we),      32'(tbl[i].we));
            chk($sformatf("tbl%0d_ack", i),  32'(cpu_ack),     32'(tbl[i].ack));
            chk($sformatf("tbl%0d_addr", i), 32'(ram_addr),    32'(tbl[i].addr));
            chk($sformatf("tbl%0d_pv", i),   32'(pixel_valid), 32'(tbl[i].pv));
            chk($sformatf("tbl%0d_pix", i),  32'(pixel),       32'(tbl[i].pix));
        end

        do_reset();
        model_reset();
        repeat (3) cyc(1'b0, 1'b0);

        run_line(640, 16, nrd, fa, la);
        chk("line0_reads", 32'(nrd), 32'd160);
        chk("line0_first", 32'(fa), 32'h0800);
        chk("line0_last",  32'(la), 32'h089F);
        for (int l = 1; l < 4; l++) begin
            run_line(640, 16, nrd, fa, la);
            chk($sformatf("line%0d_first", l), 32'(fa), 32'h0800);
        end
        run_line(640, 16, nrd, fa, la);
        chk("line4_first", 32'(fa), 32'h0900);
        run_line(700, 16, nrd, fa, la);
        chk("overrun_reads", 32'(nrd), 32'd175);
        chk("overrun_last",  32'(la), 32'h099F);

        for (int l = 0; l < 500; l++)
            run_line($urandom_range(1, 12), $urandom_range(1, 5), nrd, fa, la);
        run_line(4, 3, nrd, fa, la);
        chk("sat_reads", 32'(nrd), 32'd1);
        chk("sat_first", 32'(fa), 32'h7F00);

        for (int i = 0; i < 2000; i++)
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) != 0));

        // Reset asserted while a CPU write is on the bus.
        blank_n = 1'b0; VS = 1'b1; cpu_req = 1'b0;
        repeat (2) @(negedge vga_clk);
        #2;
        cpu_req = 1'b1; cpu_addr = 15'h5555; cpu_wdata = 8'h77;
        @(negedge vga_clk);
        #2;
        chk("abort_pre_we", 32'(ram_we), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_we",    32'(ram_we),    32'd0);
        chk("abort_ack",   32'(cpu_ack),   32'd0);
        chk("abort_addr",  32'(ram_addr),  32'd0);
        chk("abort_wdata", 32'(ram_wdata), 32'd0);
        chk("abort_pv",    32'(pixel_valid), 32'd0);
        cpu_req = 1'b0;
        @(negedge vga_clk);
        @(posedge vga_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            #2;
            chk("post_abort_ack", 32'(cpu_ack), 32'd0);
            chk("post_abort_we",  32'(ram_we),  32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/video_ram_arbiter.md
VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 15, video RAM address width.
REQ-002 SHALL have parameter FB_BASE, 15'h0800, framebuffer base address.
REQ-003 SHALL have parameter LINE_STRIDE, 256, address step between pixel rows.
REQ-004 SHALL have parameter H_PIXELS, 160, fetched pixels per row; V_ROWS, 120, rows per frame; REP, 4, horizontal clocks per pixel and scan lines per row.
REQ-005 SHALL have port vga_clk  input  1  pixel clock; all state updates on falling edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port blank_n  input  1  high in visible region, from the sync generator.
REQ-008 SHALL have port VS  input  1  vertical sync, active low.
REQ-009 SHALL have ports cpu_req  input  1 (write request, level); cpu_addr  input  ADDR_W; cpu_wdata  input  8.
REQ-010 SHALL have port cpu_ack  output  1  one-cycle pulse, write performed.
REQ-011 SHALL have ports ram_addr  output  ADDR_W; ram_wdata  output  8; ram_we  output  1; ram_re  output  1; ram_rdata  input  8 (valid one clock after ram_re).
REQ-012 SHALL have ports pixel  output  8 and pixel_valid  output  1.

Function
REQ-013 SHALL implement a state machine IDLE, VID_RD, CPU_WR; the state names the RAM cycle driven; all ram_* and cpu_ack outputs are registered.
REQ-014 SHALL keep counters phase (0..REP-1), x (0..H_PIXELS-1), rep (0..REP-1), row (0..V_ROWS-1).
REQ-015 SHALL advance phase once per clock while blank_n=1, wrapping REP-1 to 0; x increments on each phase wrap.
REQ-016 SHALL hold x at H_PIXELS-1 (no wrap) if the visible region exceeds H_PIXELS*REP clocks.
REQ-017 SHALL clear x and phase on the first clock with blank_n=0.
REQ-018 SHALL, on blank_n falling edge (1 then 0), increment rep; when rep wraps, increment row, saturating at V_ROWS-1.
REQ-019 SHALL clear row and rep while VS=0; VS takes priority over a simultaneous blank_n falling edge.
REQ-020 SHALL compute the video address as FB_BASE + row*LINE_STRIDE + x, truncated to ADDR_W (modulo wrap).
REQ-021 SHALL, on each edge where blank_n=1 and phase=0, enter VID_RD: ram_re=1, ram_we=0, ram_addr=video address.
REQ-022 SHALL otherwise, if cpu_req=1 and cpu_ack is currently 0, enter CPU_WR: ram_we=1, ram_re=0, ram_addr=cpu_addr, ram_wdata=cpu_wdata, cpu_ack=1.
REQ-023 SHALL otherwise enter IDLE with ram_we=0, ram_re=0, cpu_ack=0; ram_addr and ram_wdata hold.
REQ-024 SHALL give video absolute priority; a cpu_req colliding with a video slot is served on the next edge (worst-case wait 1 clock).
REQ-025 SHALL never issue two back-to-back CPU writes; a cpu_req still high the edge after cpu_ack is ignored for that edge.
REQ-026 SHALL latch ram_rdata into pixel on the edge after VID_RD and hold it until the next latch; pixel-to-blank_n latency is 2 clocks, to be matched downstream by delaying HS/VS/blank_n by 2.
REQ-027 SHALL drive pixel_valid=1 from the first pixel latch of a line until 2 clocks after blank_n falls; otherwise pixel_valid=0 and pixel=8'h00.
REQ-028 SHALL never assert ram_we and ram_re together.

Reset
REQ-029 SHALL, while reset_n=0, force state=IDLE, all counters 0, ram_addr=0, ram_wdata=0, ram_we=0, ram_re=0, cpu_ack=0, pixel=0, pixel_valid=0.
REQ-030 SHALL abort an in-flight write immediately on reset assertion (asynchronous); no cpu_ack for it is issued after release.
REQ-031 SHALL resume at row 0 on release, with the first fetch on the first blank_n=1 edge.

Verification
REQ-032 SHALL cover: VS low, then 640 visible clocks -> 160 reads at addresses 0x0800..0x089F, one every 4 clocks, pixel follows ram_rdata by 1 clock.
REQ-033 SHALL cover: 4 visible lines after VS -> all fetch row 0; 5th line fetches base 0x0900.
REQ-034 SHALL cover: cpu_req on a phase-0 visible edge -> VID_RD that edge, CPU_WR with cpu_ack=1 the next edge.
REQ-035 SHALL cover: cpu_req held high 6 clocks in blanking -> ram_we pattern 1,0,1,0,1,0.
REQ-036 SHALL cover: row saturation without VS (>480 lines) -> row stays 119, address base 0x0800+119*256 truncated to 15 bits.
REQ-037 SHALL cover: reset_n low during CPU_WR -> ram_we=0 before the next clock edge; all outputs 0.
